// File: rtl/riscv_wb_unit.sv
// Integer regfile writeback producer: ALU path with priority over a buffered
// long-latency path, plus a busy scoreboard that stalls issue on RAW/WAW hazards.
module riscv_wb_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned LQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid_i,
  input  logic            iss_long_i,
  input  logic [AW-1:0]   iss_rd_idx_i,
  input  logic [AW-1:0]   iss_rs1_idx_i,
  input  logic [AW-1:0]   iss_rs2_idx_i,
  output logic            iss_stall_o,
  input  logic            alu_valid_i,
  input  logic [AW-1:0]   alu_rd_idx_i,
  input  logic [XLEN-1:0] alu_rd_val_i,
  input  logic            lng_valid_i,
  output logic            lng_ready_o,
  input  logic [AW-1:0]   lng_rd_idx_i,
  input  logic [XLEN-1:0] lng_rd_val_i,
  output logic            rd_we_o,
  output logic [AW-1:0]   rd_idx_o,
  output logic [XLEN-1:0] rd_val_o,
  output logic [31:0]     busy_o
);

  localparam int unsigned PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]   lq_idx_q [LQ_DEPTH];
  logic [AW-1:0]   lq_idx_d [LQ_DEPTH];
  logic [XLEN-1:0] lq_val_q [LQ_DEPTH];
  logic [XLEN-1:0] lq_val_d [LQ_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     busy_q, busy_d;
  logic            rd_we_q, rd_we_d;
  logic [AW-1:0]   rd_idx_q, rd_idx_d;
  logic [XLEN-1:0] rd_val_q, rd_val_d;
  logic            from_lng_q, from_lng_d;

  logic        full, empty, push, pop;
  logic [31:0] busy_eff;

  assign full     = (cnt_q == CW'(LQ_DEPTH));
  assign empty    = (cnt_q == '0);
  assign push     = lng_valid_i && !full;
  assign pop      = !alu_valid_i && !empty;
  assign busy_eff = {busy_q[31:1], 1'b0};

  assign iss_stall_o = iss_valid_i && (busy_eff[iss_rs1_idx_i] ||
                                       busy_eff[iss_rs2_idx_i] ||
                                       busy_eff[iss_rd_idx_i]);
  assign lng_ready_o = !full;
  assign rd_we_o     = rd_we_q;
  assign rd_idx_o    = rd_idx_q;
  assign rd_val_o    = rd_val_q;
  assign busy_o      = busy_eff;

  always_comb begin
    lq_idx_d   = lq_idx_q;
    lq_val_d   = lq_val_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    rd_we_d    = 1'b0;
    rd_idx_d   = rd_idx_q;
    rd_val_d   = rd_val_q;
    from_lng_d = 1'b0;

    if (push) begin
      lq_idx_d[wr_ptr_q] = lng_rd_idx_i;
      lq_val_d[wr_ptr_q] = lng_rd_val_i;
      wr_ptr_d           = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (alu_valid_i) begin
      rd_we_d  = (alu_rd_idx_i != '0);
      rd_idx_d = alu_rd_idx_i;
      rd_val_d = alu_rd_val_i;
    end else if (!empty) begin
      rd_we_d    = (lq_idx_q[rd_ptr_q] != '0);
      rd_idx_d   = lq_idx_q[rd_ptr_q];
      rd_val_d   = lq_val_q[rd_ptr_q];
      from_lng_d = 1'b1;
    end

    // Clear lands on the regfile write edge; a same-cycle set on the same index wins.
    if (rd_we_q && from_lng_q) begin
      busy_d[rd_idx_q] = 1'b0;
    end
    if (iss_valid_i && iss_long_i && !iss_stall_o && (iss_rd_idx_i != '0)) begin
      busy_d[iss_rd_idx_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
        lq_idx_q[i] <= '0;
        lq_val_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      busy_q     <= '0;
      rd_we_q    <= 1'b0;
      rd_idx_q   <= '0;
      rd_val_q   <= '0;
      from_lng_q <= 1'b0;
    end else begin
      lq_idx_q   <= lq_idx_d;
      lq_val_q   <= lq_val_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      rd_we_q    <= rd_we_d;
      rd_idx_q   <= rd_idx_d;
      rd_val_q   <= rd_val_d;
      from_lng_q <= from_lng_d;
    end
  end

endmodule

// File: tb/tb_riscv_wb_unit.sv
// Bench for riscv_wb_unit: ALU vector table, hand-written hazard/buffer sequences,
// and a cycle monitor checking every write against a queue of accepted long results.
module tb_riscv_wb_unit;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            iss_valid_i, iss_long_i;
  logic [AW-1:0]   iss_rd_idx_i, iss_rs1_idx_i, iss_rs2_idx_i;
  logic            iss_stall_o;
  logic            alu_valid_i;
  logic [AW-1:0]   alu_rd_idx_i;
  logic [XLEN-1:0] alu_rd_val_i;
  logic            lng_valid_i, lng_ready_o;
  logic [AW-1:0]   lng_rd_idx_i;
  logic [XLEN-1:0] lng_rd_val_i;
  logic            rd_we_o;
  logic [AW-1:0]   rd_idx_o;
  logic [XLEN-1:0] rd_val_o;
  logic [31:0]     busy_o;

  always #5 clk = ~clk;

  riscv_wb_unit #(.XLEN(XLEN), .AW(AW), .LQ_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .iss_valid_i(iss_valid_i), .iss_long_i(iss_long_i),
    .iss_rd_idx_i(iss_rd_idx_i), .iss_rs1_idx_i(iss_rs1_idx_i),
    .iss_rs2_idx_i(iss_rs2_idx_i), .iss_stall_o(iss_stall_o),
    .alu_valid_i(alu_valid_i), .alu_rd_idx_i(alu_rd_idx_i), .alu_rd_val_i(alu_rd_val_i),
    .lng_valid_i(lng_valid_i), .lng_ready_o(lng_ready_o),
    .lng_rd_idx_i(lng_rd_idx_i), .lng_rd_val_i(lng_rd_val_i),
    .rd_we_o(rd_we_o), .rd_idx_o(rd_idx_o), .rd_val_o(rd_val_o), .busy_o(busy_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard: long results queued when accepted, popped when the writeback slot frees.
  typedef struct packed {
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] val;
  } ent_t;

  ent_t            mq[$];
  logic [31:0]     mb;
  logic            m_we, m_lng;
  logic [AW-1:0]   m_idx;
  logic [XLEN-1:0] m_val;
  logic            wrap_phase = 1'b0;
  int              wrap_writes = 0;

  always @(posedge clk) begin : model
    logic [31:0] nb;
    logic        stall;
    int          sz;
    ent_t        e;
    if (rst) begin
      mq.delete();
      mb    <= '0;
      m_we  <= 1'b0;
      m_lng <= 1'b0;
      m_idx <= '0;
      m_val <= '0;
    end else begin
      stall = iss_valid_i && (mb[iss_rs1_idx_i] || mb[iss_rs2_idx_i] || mb[iss_rd_idx_i]);
      nb = mb;
      if (m_we && m_lng) nb[m_idx] = 1'b0;
      if (iss_valid_i && iss_long_i && !stall && iss_rd_idx_i != 0) nb[iss_rd_idx_i] = 1'b1;
      nb[0] = 1'b0;
      mb <= nb;
      sz = mq.size();
      if (alu_valid_i) begin
        m_we  <= (alu_rd_idx_i != 0);
        m_lng <= 1'b0;
        m_idx <= alu_rd_idx_i;
        m_val <= alu_rd_val_i;
      end else if (sz > 0) begin
        e = mq.pop_front();
        m_we  <= (e.idx != 0);
        m_lng <= 1'b1;
        m_idx <= e.idx;
        m_val <= e.val;
      end else begin
        m_we  <= 1'b0;
        m_lng <= 1'b0;
      end
      if (lng_valid_i && sz < 2) begin
        e.idx = lng_rd_idx_i;
        e.val = lng_rd_val_i;
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("mon_we", rd_we_o, m_we);
      if (m_we) begin
        chk("mon_idx", rd_idx_o, m_idx);
        chk("mon_val", rd_val_o, m_val);
      end
      chk("mon_busy", busy_o, mb);
      chk("mon_ready", lng_ready_o, mq.size() < 2);
      chk("mon_stall", iss_stall_o,
          iss_valid_i && (mb[iss_rs1_idx_i] || mb[iss_rs2_idx_i] || mb[iss_rd_idx_i]));
      if (wrap_phase && rd_we_o) wrap_writes++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic            v;
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] val;
    logic            exp_we;
    logic [AW-1:0]   exp_idx;
    logic [XLEN-1:0] exp_val;
  } alu_vec_t;

  alu_vec_t tv[5];

  initial begin
    int  sent;
    logic rdy;

    tv[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b1, 5'd3,  32'hDEADBEEF};
    tv[1] = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  32'h12345678};
    tv[2] = '{1'b0, 5'd9,  32'h0BADF00D, 1'b0, 5'd0,  32'h12345678};
    tv[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF};
    tv[4] = '{1'b0, 5'd1,  32'h00000001, 1'b0, 5'd31, 32'hFFFFFFFF};

    rst = 1'b1;
    iss_valid_i = 0; iss_long_i = 0; iss_rd_idx_i = 0; iss_rs1_idx_i = 0; iss_rs2_idx_i = 0;
    alu_valid_i = 0; alu_rd_idx_i = 0; alu_rd_val_i = 0;
    lng_valid_i = 0; lng_rd_idx_i = 0; lng_rd_val_i = 0;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_we", rd_we_o, 0);
    chk("rst_idx", rd_idx_o, 0);
    chk("rst_val", rd_val_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", lng_ready_o, 1);

    for (int i = 0; i < 5; i++) begin
      alu_valid_i  = tv[i].v;
      alu_rd_idx_i = tv[i].idx;
      alu_rd_val_i = tv[i].val;
      cyc();
      chk($sformatf("alu%0d_we", i), rd_we_o, tv[i].exp_we);
      chk($sformatf("alu%0d_idx", i), rd_idx_o, tv[i].exp_idx);
      chk($sformatf("alu%0d_val", i), rd_val_o, tv[i].exp_val);
    end
    alu_valid_i = 0;

    // Scoreboard round trip on x7
    iss_valid_i = 1; iss_long_i = 1; iss_rd_idx_i = 7; iss_rs1_idx_i = 1; iss_rs2_idx_i = 2;
    #1 chk("rt_nostall", iss_stall_o, 0);
    cyc();
    chk("rt_busy_set", busy_o[7], 1);
    iss_long_i = 0; iss_rd_idx_i = 8; iss_rs1_idx_i = 7;
    #1 chk("rt_stall", iss_stall_o, 1);
    lng_valid_i = 1; lng_rd_idx_i = 7; lng_rd_val_i = 32'h55;
    cyc();
    lng_valid_i = 0;
    chk("rt_n1_we", rd_we_o, 0);
    cyc();
    chk("rt_n2_we", rd_we_o, 1);
    chk("rt_n2_idx", rd_idx_o, 7);
    chk("rt_n2_val", rd_val_o, 32'h55);
    chk("rt_n2_busy", busy_o[7], 1);
    cyc();
    chk("rt_busy_clr", busy_o[7], 0);
    chk("rt_stall_drop", iss_stall_o, 0);
    iss_valid_i = 0;

    // Priority: ALU holds the buffered x9 for three cycles
    iss_valid_i = 1; iss_long_i = 1; iss_rd_idx_i = 9; iss_rs1_idx_i = 0; iss_rs2_idx_i = 0;
    cyc();
    iss_valid_i = 0; iss_long_i = 0;
    chk("pri_busy9", busy_o[9], 1);
    lng_valid_i = 1; lng_rd_idx_i = 9; lng_rd_val_i = 32'h1;
    alu_valid_i = 1; alu_rd_idx_i = 20; alu_rd_val_i = 32'h100;
    cyc();
    lng_valid_i = 0;
    chk("pri_a1", rd_idx_o, 20);
    alu_rd_idx_i = 21; alu_rd_val_i = 32'h101;
    cyc();
    chk("pri_a2", rd_idx_o, 21);
    alu_rd_idx_i = 22; alu_rd_val_i = 32'h102;
    cyc();
    chk("pri_a3", rd_idx_o, 22);
    chk("pri_hold_busy", busy_o[9], 1);
    alu_valid_i = 0;
    cyc();
    chk("pri_x9_we", rd_we_o, 1);
    chk("pri_x9_idx", rd_idx_o, 9);
    chk("pri_x9_val", rd_val_o, 32'h1);
    cyc();
    chk("pri_busy9_clr", busy_o[9], 0);

    // Full buffer back-pressure
    alu_valid_i = 1; alu_rd_idx_i = 12; alu_rd_val_i = 32'hC0;
    lng_valid_i = 1; lng_rd_idx_i = 10; lng_rd_val_i = 32'hA0;
    cyc();
    chk("full_rdy1", lng_ready_o, 1);
    lng_rd_idx_i = 11; lng_rd_val_i = 32'hA1;
    cyc();
    chk("full_rdy0", lng_ready_o, 0);
    lng_rd_idx_i = 12; lng_rd_val_i = 32'hA2;
    cyc();
    chk("full_rdy0b", lng_ready_o, 0);
    cyc();
    lng_valid_i = 0; alu_valid_i = 0;
    cyc();
    chk("full_x10_idx", rd_idx_o, 10);
    chk("full_x10_val", rd_val_o, 32'hA0);
    chk("full_rdy_back", lng_ready_o, 1);
    cyc();
    chk("full_x11_idx", rd_idx_o, 11);
    chk("full_x11_val", rd_val_o, 32'hA1);
    cyc();
    chk("full_no3rd", rd_we_o, 0);

    // Wrap-around stream with overlapping push/pop and periodic ALU blocking
    wrap_phase = 1'b1;
    sent = 0;
    for (int c = 0; c < 60 && sent < 6; c++) begin
      lng_valid_i  = 1;
      lng_rd_idx_i = AW'(sent + 1);
      lng_rd_val_i = 32'h100 + 32'(sent + 1);
      alu_valid_i  = (c % 3 == 0);
      alu_rd_idx_i = 0;
      rdy = lng_ready_o;
      cyc();
      if (rdy) sent++;
    end
    lng_valid_i = 0; alu_valid_i = 0;
    cyc(); cyc(); cyc(); cyc();
    wrap_phase = 1'b0;
    chk("wrap_sent", sent, 6);
    chk("wrap_writes", wrap_writes, 6);
    chk("wrap_drained", mq.size(), 0);

    // Reset in the middle of buffered traffic
    iss_valid_i = 1; iss_long_i = 1; iss_rd_idx_i = 5;
    cyc();
    iss_valid_i = 0; iss_long_i = 0;
    alu_valid_i = 1; alu_rd_idx_i = 0;
    lng_valid_i = 1; lng_rd_idx_i = 5; lng_rd_val_i = 32'h5;
    cyc();
    lng_rd_idx_i = 6; lng_rd_val_i = 32'h6;
    cyc();
    chk("mid_full", lng_ready_o, 0);
    chk("mid_busy5", busy_o[5], 1);
    rst = 1'b1;
    lng_valid_i = 0; alu_valid_i = 0;
    #1;
    chk("mid_rst_we", rd_we_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_ready", lng_ready_o, 1);
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("mid_nowr%0d", k), rd_we_o, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_wb_unit.md
Name: riscv_wb_unit

Overview:
Writeback-side producer for the integer register file. It drives the regfile's single write port (rd_we/rd_idx/rd_val) from two result sources:
- a single-cycle ALU path, which has priority;
- a long-latency path (LSU/MDU) using a valid/ready handshake and a 2-entry buffer.

It also keeps a 32-entry busy scoreboard of pending long-latency destinations and raises an issue stall on RAW/WAW hazards against them.

Parameters:
XLEN, 32, register data width (matches RegBus).
AW, 5, register index width (matches RegAddrBus).
LQ_DEPTH, 2, long-result buffer depth (power of two, >=2).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
iss_valid_i  input  1  an instruction is being presented for issue this cycle.
iss_long_i  input  1  the issuing instruction is long-latency and will write back via the lng port.
iss_rd_idx_i  input  AW  destination of the issuing instruction.
iss_rs1_idx_i  input  AW  source 1 of the issuing instruction.
iss_rs2_idx_i  input  AW  source 2 of the issuing instruction.
iss_stall_o  output  1  hazard stall; the issue is not taken while this is high.
alu_valid_i  input  1  ALU result valid; there is no back-pressure on this path.
alu_rd_idx_i  input  AW  ALU destination.
alu_rd_val_i  input  XLEN  ALU result.
lng_valid_i  input  1  long-latency result valid.
lng_ready_o  output  1  long-latency buffer can accept.
lng_rd_idx_i  input  AW  long-latency destination.
lng_rd_val_i  input  XLEN  long-latency result.
rd_we_o  output  1  regfile write enable, registered.
rd_idx_o  output  AW  regfile write index, registered.
rd_val_o  output  XLEN  regfile write data, registered.
busy_o  output  32  scoreboard vector; bit i set means xi has a pending long write.

Behaviour:
Reset (asynchronous, rst high):
- rd_we_o=0, rd_idx_o=0, rd_val_o=0, busy_o=0.
- Buffer emptied; lng_ready_o=1.
- Any in-flight buffered results are discarded.

Issue stall (combinational):
- iss_stall_o = iss_valid_i & (busy[rs1] | busy[rs2] | busy[rd]).
- Index 0 never counts as busy.

Scoreboard:
- Set: on a clk edge where iss_valid_i & iss_long_i & !iss_stall_o & (iss_rd_idx_i != 0), set busy[iss_rd_idx_i].
- Clear: on a clk edge where rd_we_o=1 and the current write came from the long buffer, clear busy[rd_idx_o]. The clear coincides with the regfile's write edge, so no forwarding is needed.
- Set and clear on the same index in the same cycle: set wins. This is unreachable in practice because WAW stalls it.
- busy[0] is constant 0.

Long buffer:
- Circular FIFO of LQ_DEPTH {idx,val} entries with read/write pointers and an occupancy counter.
- lng_ready_o = !full. It is registered-state based, with no combinational path from lng_valid_i.
- Push when lng_valid_i & lng_ready_o.
- No pass-through: when the buffer is full, ready stays low even if a pop happens in the same cycle.
- Push and pop in the same cycle: the count is unchanged and both pointers advance with wrap-around.

Write selection (one write per cycle):
- ALU wins. If alu_valid_i, then next cycle rd_we_o = (alu_rd_idx_i != 0), rd_idx_o = alu_rd_idx_i, rd_val_o = alu_rd_val_i. The buffer head is held.
- Otherwise, if the buffer is non-empty: pop the head, and next cycle drive the head entry with rd_we_o = (idx != 0).
- Otherwise rd_we_o=0. rd_idx_o/rd_val_o hold their previous values.

Writes to x0:
- rd_we_o stays low.
- A buffered x0 entry is still popped and consumes its slot.

Latency:
- ALU: valid in cycle N gives rd_we_o in N+1.
- Long, empty buffer and no ALU traffic: accepted at the end of N, rd_we_o in N+2, busy bit clears at the end of N+2.

Starvation:
- Continuous ALU traffic blocks the buffer indefinitely. The issue logic bounds this, and it is not handled here.

Test Plan:
- Reset mid-operation: fill 2 entries (x5, x6), assert rst for 1 cycle -> rd_we_o=0, busy_o=0, lng_ready_o=1; no further writes.
- ALU path: alu_valid_i=1, idx=3, val=0xDEADBEEF in cycle N -> cycle N+1 rd_we_o=1, rd_idx_o=3, rd_val_o=0xDEADBEEF; idx=0 gives rd_we_o=0.
- Scoreboard round-trip: issue long rd=7 -> busy_o[7]=1. Issue with rs1=7 -> iss_stall_o=1. lng result x7=0x55 with no ALU -> rd_we_o high 2 cycles later, busy_o[7] clears after that edge, stall drops.
- Priority/hold: buffer holds x9=0x1; alu_valid_i high 3 consecutive cycles -> 3 ALU writes, then x9 written in the 4th cycle, busy_o[9] clears.
- Full/back-pressure: with ALU busy, push x10 and x11 -> lng_ready_o=0 and a 3rd valid is not accepted. ALU idles -> x10 then x11 written in order, ready returns high after the first pop.
- Wrap-around: stream 6 long results (x1..x6) with push/pop overlap -> all 6 written in order, exact values, no loss or duplication.
